// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// if_fetch_ctrl
// ----------------------------------------------------------------------------
// Instruction-fetch controller. This block is the initiator side of the
// instruction-memory read port. It owns the program counter and drives a
// word address into a synchronous instruction memory, which returns the
// addressed word one clock later. The block also tracks which PC the
// returned word belongs to. It presents PC, instruction and valid to the
// IF/ID register.
//
// Stalls keep the in-flight word by capturing it into a hold register.
// Branch redirects squash the wrong-path word that is currently being
// fetched, which costs one bubble.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   Defined   : a redirect to a target with [1:0] != 0 enters a TRAP state.
//               In TRAP, FETCH_EXC is raised, IF_VALID is held low, the PC is
//               frozen and STALL is ignored. Only an aligned redirect leaves
//               TRAP.
//   Undefined : the low two target bits are dropped and FETCH_EXC is tied 0.
//
// Parameters
//   RESET_PC       PC loaded on reset (bits [1:0] must be 0)
//
// Ports
//   CLK            clock, all state changes on the rising edge
//   RESET_N        asynchronous active-low reset
//   IMEM_ADDR      registered word-aligned fetch address to instruction memory
//   IMEM_INSTR     memory read data for the address sampled at the last edge
//   STALL          hazard-unit hold request
//   BRANCH_TAKEN   redirect request from EX
//   BRANCH_TARGET  redirect address
//   IF_PC          PC of the word on IF_INSTR
//   IF_INSTR       fetched instruction to IF/ID
//   IF_VALID       IF_PC/IF_INSTR are a live, correct-path instruction
//   FETCH_EXC      misaligned-target trap flag (0 unless the trap is enabled)
// ============================================================================
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_INSTR,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTR,
    output logic        IF_VALID,
    output logic        FETCH_EXC
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] S_TRAP = 2'd3;
`endif

    // Sequential PC step; wraps modulo 2^32 so 32'hFFFF_FFFC is followed by 0.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // The memory is word addressed, so the low two target bits never reach it.
    function automatic logic [31:0] align_target(input logic [31:0] tgt);
        return {tgt[31:2], 2'b00};
    endfunction

    logic [1:0]  state_q,       state_d;
    logic [31:0] pc_p0,         pc_d;
    logic [31:0] pend_pc_p1,    pend_pc_d;
    logic        vld_p1,        vld_d;
    logic [31:0] hold_instr_p1, hold_instr_d;
    logic        hold_vld_p1,   hold_vld_d;
    logic        trap_target;
    logic        in_trap;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        exc_q, exc_d;

    assign trap_target = (BRANCH_TARGET[1:0] != 2'b00);
    assign in_trap     = (state_q == S_TRAP);
    assign FETCH_EXC   = exc_q;
`else
    // The low target bits are intentionally discarded in this build.
    logic unused_target_lsbs;

    assign unused_target_lsbs = ^BRANCH_TARGET[1:0];
    assign trap_target        = 1'b0;
    assign in_trap            = 1'b0;
    assign FETCH_EXC          = 1'b0;
`endif

    // ---- Next-state decision, evaluated in redirect > stall > advance order
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_p0;
        pend_pc_d    = pend_pc_p1;
        vld_d        = vld_p1;
        hold_instr_d = hold_instr_p1;
        hold_vld_d   = hold_vld_p1;
`ifdef FETCH_MISALIGN_TRAP_EN
        exc_d        = exc_q;
`endif

        if (BRANCH_TAKEN) begin
            // The word arriving at this edge was fetched down the wrong path.
            vld_d      = 1'b0;
            hold_vld_d = 1'b0;
            if (trap_target) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state_d = S_TRAP;
                exc_d   = 1'b1;
`endif
            end else begin
                pc_d    = align_target(BRANCH_TARGET);
                state_d = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                exc_d   = 1'b0;
`endif
            end
        end else if (in_trap) begin
            // Frozen until an aligned redirect arrives; STALL has no effect.
            vld_d = 1'b0;
        end else if (STALL) begin
            // The memory re-samples the unchanged PC at this edge and will
            // overwrite IMEM_INSTR, so the live word must be captured first.
            // Only the first stalled edge captures; HOLD keeps that copy.
            if (vld_p1 && (state_q != S_HOLD)) begin
                hold_instr_d = IMEM_INSTR;
                hold_vld_d   = 1'b1;
                state_d      = S_HOLD;
            end
        end else begin
            pend_pc_d  = pc_p0;
            vld_d      = 1'b1;
            pc_d       = pc_incr(pc_p0);
            hold_vld_d = 1'b0;
            state_d    = S_RUN;
        end
    end

    // ---- Fetch-address (p0) and returned-word (p1) registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            pc_p0         <= RESET_PC;
            pend_pc_p1    <= RESET_PC;
            vld_p1        <= 1'b0;
            hold_instr_p1 <= 32'h0000_0000;
            hold_vld_p1   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            exc_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_p0         <= pc_d;
            pend_pc_p1    <= pend_pc_d;
            vld_p1        <= vld_d;
            hold_instr_p1 <= hold_instr_d;
            hold_vld_p1   <= hold_vld_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            exc_q         <= exc_d;
`endif
        end
    end

    assign IMEM_ADDR = pc_p0;
    assign IF_PC     = pend_pc_p1;
    assign IF_VALID  = vld_p1;
    assign IF_INSTR  = hold_vld_p1 ? hold_instr_p1 : IMEM_INSTR;

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller: the initiator side of the instruction-memory read port. It owns the program counter and drives a word address into the synchronous instruction memory, which returns the addressed word one clock later. It tracks which PC the returned word belongs to and presents PC, instruction and valid to the IF/ID register. It also handles pipeline stalls without losing the in-flight word, and squashes wrong-path fetches on branch redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- CLK  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IMEM_ADDR  out  32  fetch address to instruction memory. Registered; bits [1:0] always 0.
- IMEM_INSTR  in  32  memory read data. Holds mem[IMEM_ADDR>>2] as sampled at the previous rising edge.
- STALL  in  1  hazard unit hold request.
- BRANCH_TAKEN  in  1  redirect request from EX.
- BRANCH_TARGET  in  32  redirect address.
- IF_PC  out  32  PC of the word on IF_INSTR.
- IF_INSTR  out  32  fetched instruction to IF/ID.
- IF_VALID  out  1  IF_PC/IF_INSTR are a live, correct-path instruction.
- FETCH_EXC  out  1  misaligned-target trap flag. Present always; see Configuration.

## Operation
- Internal registers:
  - pc_q drives IMEM_ADDR.
  - pend_pc/pend_v: the word the memory is returning this cycle.
  - hold_instr/hold_v: captured word during a stall.
- States:
  - IDLE: after reset, nothing in flight, pend_v=0.
  - RUN
  - HOLD: stalled with a captured word.
  - TRAP: only with the macro.
- Outputs:
  - IF_PC = pend_pc.
  - IF_VALID = pend_v.
  - IF_INSTR = hold_v ? hold_instr : IMEM_INSTR.
- Per rising edge, in priority order:
  1. BRANCH_TAKEN=1:
     - pc_q <= {BRANCH_TARGET[31:2],2'b00}.
     - pend_v <= 0 (squash the word being fetched at this edge); hold_v <= 0.
     - Next state RUN. Wins over STALL.
  2. STALL=1:
     - pc_q and pend_* held.
     - If pend_v && !hold_v: hold_instr <= IMEM_INSTR, hold_v <= 1 (RUN→HOLD). Required because the memory re-samples pc_q and overwrites IMEM_INSTR.
     - HOLD stays HOLD.
  3. Otherwise, advance:
     - pend_pc <= pc_q, pend_v <= 1.
     - pc_q <= pc_q + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
     - hold_v <= 0. IDLE/HOLD → RUN.
- IF/ID latches IF_* on every edge with STALL=0. A word is consumed exactly once.
- IMEM_INSTR is ignored whenever pend_v=0. This covers reset, post-redirect, and memory reset output.

## Timing
- Reset (asynchronous, immediate):
  - pc_q=IMEM_ADDR=RESET_PC.
  - pend_pc=RESET_PC, pend_v=0.
  - hold_instr=0, hold_v=0.
  - IF_VALID=0, FETCH_EXC=0, state IDLE.
- Fetch latency: IF_VALID first rises one cycle after the first rising edge following RESET_N deassertion, with IF_PC=RESET_PC.
- Throughput: one instruction per cycle with STALL=0 and no redirect.
- Redirect penalty: one bubble cycle.
  - IF_VALID=0 in the cycle after the redirect edge.
  - The target's word appears with IF_VALID=1 in the cycle after that.
- Stall: IF_PC/IF_INSTR/IF_VALID are bit-stable for every cycle STALL is high, for any stall length. On release, the next sequential word follows with no bubble.
- Reset asserted mid-stall or mid-redirect: all state cleared immediately; no word from before reset is ever presented with IF_VALID=1.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A BRANCH_TAKEN edge with BRANCH_TARGET[1:0]≠0 enters TRAP.
  - FETCH_EXC=1 from the next cycle; IF_VALID held 0; pc_q frozen; STALL ignored.
  - TRAP exits only on a BRANCH_TAKEN with an aligned target, which behaves as a normal redirect and clears FETCH_EXC.
- Not defined:
  - BRANCH_TARGET[1:0] silently dropped.
  - FETCH_EXC tied 0; no TRAP state.

## Test plan
- Reset release, RESET_PC=0, memory preloaded mem[i]=32'h1000_0000+i, STALL=0 → IF_VALID rises one cycle after first edge; IF_PC 0,4,8 with IF_INSTR 32'h1000_0000, 32'h1000_0001, 32'h1000_0002 on consecutive cycles.
- STALL high for 3 cycles while IF_PC=8 → IF_PC=8 and IF_INSTR=32'h1000_0002 stable for all 3 cycles; after release IF_PC=12 with 32'h1000_0003, no bubble.
- BRANCH_TAKEN with BRANCH_TARGET=32'h40 while IF_PC=4 → exactly one IF_VALID=0 cycle, then IF_PC=32'h40, IF_INSTR=32'h1000_0010.
- BRANCH_TAKEN and STALL both high, target 32'h80 → redirect taken; next valid is IF_PC=32'h80, IF_INSTR=32'h1000_0020.
- RESET_N pulled low mid-stall → IF_VALID=0 and IMEM_ADDR=RESET_PC immediately, without waiting for a clock edge; restart identical to the first scenario.
- With FETCH_MISALIGN_TRAP_EN, BRANCH_TARGET=32'h42 → FETCH_EXC=1, IF_VALID=0 for 5 cycles; then branch to 32'h44 → FETCH_EXC=0, IF_PC=32'h44 with IF_VALID=1 after one bubble.
